// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the Riscv core front end.
//   XLEN          - architectural PC / data width
//   RESET_PC      - default fetch address after reset
//   NOP           - canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t - layout of one prefetch entry: {inst, pc}, inst in the MSBs
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH circular buffer holding prefetched {inst, pc} entries.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write din at the tail this cycle
//   pop         - drop the head this cycle (caller only pops when level != 0)
//   flush       - empty the buffer; wins over a push in the same cycle
//   head        - entry at the head (stale contents when empty)
//   level       - number of occupied entries, 0..DEPTH
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Storage is cleared so the head reads as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));

    // The fetcher's credit scheme must never overfill or underflow the buffer.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (pop && !flush) |-> (level != '0));

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: streaming instruction fetcher in front of a synchronous ROM.
// Ports:
//   clk, rst_n      - core clock, asynchronous active-low reset
//   rom_addr        - ROM word address (fetch_pc[ROM_AW+1:2]), combinational
//   rom_en          - ROM read request; data arrives on rom_inst the next cycle
//   rom_inst        - ROM read data
//   redirect_valid  - execute redirects fetch to redirect_pc (low 2 bits ignored)
//   redirect_pc     - redirect target
//   inst_valid      - head of prefetch buffer is valid
//   inst_ready      - decode accepts the head
//   inst_out        - head instruction word
//   inst_pc         - PC of the head instruction
//   fifo_level      - occupied prefetch entries (debug/perf)
//
// Handshake: an entry transfers on every cycle where inst_valid && inst_ready are
// both high at the clock edge; while inst_valid && !inst_ready the head
// (inst_out, inst_pc) holds steady, and inst_valid never drops without a transfer
// except on a redirect or reset.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter int              ROM_AW     = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ROM_AW-1:0]             rom_addr,
    output logic                          rom_en,
    input  logic [31:0]                   rom_inst,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_out,
    output logic [XLEN-1:0]               inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 32 + XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic            resp_pending;
    logic [LW-1:0]   level;
    logic [LW-1:0]   committed;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    // Credit: entries already buffered plus the one ROM read in flight. Issuing
    // only while this is below depth guarantees every response finds a free slot.
    assign committed = level + LW'(resp_pending);

    // Gated by rst_n so the ROM sees no request while the core is held in reset.
    assign rom_en   = rst_n && !redirect_valid && (committed < LW'(FIFO_DEPTH));
    assign rom_addr = fetch_pc[ROM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= '0;
            resp_pending <= 1'b0;
        end else if (redirect_valid) begin
            // Any read issued last cycle is abandoned: its data is never pushed.
            fetch_pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            resp_pending <= 1'b0;
        end else if (rom_en) begin
            fetch_pc     <= fetch_pc + XLEN'(4);
            resp_pc      <= fetch_pc;
            resp_pending <= 1'b1;
        end else begin
            resp_pending <= 1'b0;
        end
    end

    assign push = resp_pending;
    assign pop  = inst_valid && inst_ready;

    // Entry layout matches fetch_entry_t: instruction in the upper 32 bits.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({rom_inst, resp_pc}),
        .head  (head),
        .level (level)
    );

    assign inst_valid = (level != '0);
    assign inst_out   = head[EW-1:XLEN];
    assign inst_pc    = head[XLEN-1:0];
    assign fifo_level = level;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;

    localparam int W = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst2_n;

    // DUT 1: default parameters, 256-word ROM where word n holds n
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_level;

    // DUT 2: RESET_PC near the top of the address space, 30-bit ROM address
    logic [29:0] rom_addr2;
    logic        rom_en2;
    logic [31:0] rom_inst2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst_out2;
    logic [31:0] inst_pc2;
    logic [2:0]  fifo_level2;

    riscv_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fifo_level     (fifo_level)
    );

    riscv_fetch_unit #(
        .XLEN       (32),
        .ROM_AW     (30),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'hFFFF_FFF8)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst2_n),
        .rom_addr       (rom_addr2),
        .rom_en         (rom_en2),
        .rom_inst       (rom_inst2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (inst_valid2),
        .inst_ready     (inst_ready2),
        .inst_out       (inst_out2),
        .inst_pc        (inst_pc2),
        .fifo_level     (fifo_level2)
    );

    // Synchronous ROM models: word n holds n
    always @(posedge clk) if (rom_en)  rom_inst  <= {24'h0, rom_addr};
    always @(posedge clk) if (rom_en2) rom_inst2 <= {2'b00, rom_addr2};

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q2[$];
    logic [W-1:0] mon_e;
    logic [W-1:0] mon_e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for DUT 1: every accepted head must be the next expected entry
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got pc %0h inst %0h, expected no word", inst_pc, inst_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_pc", 64'(inst_pc), 64'(mon_e[31:0]));
                check("pop_inst", 64'(inst_out), 64'(mon_e[63:32]));
            end
        end
    end

    // Monitor for DUT 2
    always @(negedge clk) begin
        if (rst2_n && inst_valid2 && inst_ready2) begin
            if (exp_q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop2: got pc %0h inst %0h, expected no word", inst_pc2, inst_out2);
            end else begin
                mon_e2 = exp_q2.pop_front();
                check("pop2_pc", 64'(inst_pc2), 64'(mon_e2[31:0]));
                check("pop2_inst", 64'(inst_out2), 64'(mon_e2[63:32]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream from pc0 onward; ROM word n holds n, so inst = pc >> 2
    task automatic push_stream(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(4 * i);
            exp_q.push_back({24'h0, pc[9:2], pc});
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        exp_q.delete();
    endtask

    // Ready held high for n cycles; the head must be valid in every one of them
    task automatic run_ready(input int n);
        inst_ready = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("no_gap", 64'(inst_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        check("stream_done", 64'(exp_q.size()), 64'd0);
    endtask

    // Accept until every expected entry is consumed, optionally with random ready
    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        inst_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
            if (rnd) inst_ready = 1'($urandom_range(0, 1));
        end
        inst_ready = 1'b0;
        check("drain_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        inst_ready     = 1'b0;
        inst_ready2    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst_out), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_rom_en", 64'(rom_en), 64'd0);

        // 1. Stream from reset with ready high: first valid after the 2nd edge
        inst_ready = 1'b1;
        push_stream(32'h0, 8);
        rst_n = 1'b1;
        tick();
        check("t1_not_valid_edge1", 64'(inst_valid), 64'd0);
        tick();
        check("t1_valid_edge2", 64'(inst_valid), 64'd1);
        run_ready(8);

        // 2. Stall for 10 cycles: level saturates, ROM idle, head stays at pc 0
        do_reset();
        rst_n = 1'b1;
        repeat (10) tick();
        check("t2_level_full", 64'(fifo_level), 64'd4);
        check("t2_rom_en_idle", 64'(rom_en), 64'd0);
        check("t2_valid", 64'(inst_valid), 64'd1);
        check("t2_head_pc", 64'(inst_pc), 64'h0);
        tick();
        check("t2_head_pc_hold", 64'(inst_pc), 64'h0);
        push_stream(32'h0, 16);
        run_ready(16);

        // 3. Redirect to 0x40 while three entries are buffered and a read is in flight
        do_reset();
        rst_n = 1'b1;
        n = 0;
        while (fifo_level != 3'd3 && n < 10) begin
            tick();
            n++;
        end
        check("t3_level3", 64'(fifo_level), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_flushed_valid", 64'(inst_valid), 64'd0);
        check("t3_flushed_level", 64'(fifo_level), 64'd0);
        tick();
        check("t3_lat_cycle1", 64'(inst_valid), 64'd0);
        tick();
        check("t3_lat_cycle2", 64'(inst_valid), 64'd1);
        check("t3_first_pc", 64'(inst_pc), 64'h40);
        check("t3_first_inst", 64'(inst_out), 64'd16);
        push_stream(32'h40, 6);
        run_ready(6);

        // 4a. Misaligned redirect target: low bits dropped, ROM idle that cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        check("t4_rom_en_redirect", 64'(rom_en), 64'd0);
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed_valid", 64'(inst_valid), 64'd0);
        tick();
        tick();
        check("t4_align_pc", 64'(inst_pc), 64'h40);
        check("t4_align_inst", 64'(inst_out), 64'h10);
        push_stream(32'h40, 4);
        run_ready(4);

        // 4b. Pop in the redirect cycle completes; back-to-back redirects, last wins
        push_stream(32'h50, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        inst_ready     = 1'b1;
        tick();
        check("t4_pop_in_redirect", 64'(exp_q.size()), 64'd0);
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        check("t4_b2b_valid", 64'(inst_valid), 64'd0);
        push_stream(32'h20, 6);
        drain(40, 1'b0);

        // 5. PC wrap at the top of the address space
        check("t5_rst_valid", 64'(inst_valid2), 64'd0);
        check("t5_rst_level", 64'(fifo_level2), 64'd0);
        exp_q2.push_back({32'h3FFF_FFFE, 32'hFFFF_FFF8});
        exp_q2.push_back({32'h3FFF_FFFF, 32'hFFFF_FFFC});
        exp_q2.push_back({32'h0000_0000, 32'h0000_0000});
        exp_q2.push_back({32'h0000_0001, 32'h0000_0004});
        inst_ready2 = 1'b1;
        rst2_n      = 1'b1;
        n = 0;
        while (exp_q2.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        inst_ready2 = 1'b0;
        check("t5_wrap_done", 64'(exp_q2.size()), 64'd0);

        // 6. Asynchronous reset mid-stream with a partly full buffer
        do_reset();
        push_stream(32'h0, 2);
        inst_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        inst_ready = 1'b0;
        tick();
        check("t6_pre_pc", 64'(inst_pc), 64'h8);
        check("t6_pre_level", 64'(fifo_level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(inst_valid), 64'd0);
        check("t6_rst_inst", 64'(inst_out), 64'd0);
        check("t6_rst_pc", 64'(inst_pc), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        check("t6_rst_rom_en", 64'(rom_en), 64'd0);
        tick();
        exp_q.delete();
        push_stream(32'h0, 6);
        rst_n = 1'b1;
        drain(200, 1'b1);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
